// File: rtl/ctrl_rst_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_rst_pkg
//  Brief    : Shared state encoding and default timing for the reset sequencer
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    // Simulation builds use short delays so SoC-level runs reach RUN quickly
`ifdef SOC_SIM
    localparam int c_hold_cyc_def = 4;
    localparam int c_rel_dly_def  = 2;
`else
    localparam int c_hold_cyc_def = 16;
    localparam int c_rel_dly_def  = 8;
`endif

endpackage : ctrl_rst_pkg
`default_nettype wire

// File: rtl/ctrl_rst_dly.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_rst_dly
//  Brief    : Loadable up-counter with terminal-count flag for hold/step delays
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_rst_dly #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [CNT_W-1:0] i_ld_val,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ld) begin
            r_cnt <= i_ld_val;
        end else if (i_en) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_term);

endmodule : ctrl_rst_dly
`default_nettype wire

// File: rtl/ctrl_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_rst_seq
//  Brief    : Ordered per-domain reset release with soft partial-reset handshake
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_rst_seq
    import ctrl_rst_pkg::*;
#(
    parameter int NDOM     = 4,
    parameter int HOLD_CYC = c_hold_cyc_def,
    parameter int REL_DLY  = c_rel_dly_def,
    parameter int CNT_W    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soft_req,
    input  logic [NDOM-1:0] soft_mask,
    output logic [NDOM-1:0] dom_rst,
    output logic            busy,
    output logic            seq_done,
    output logic            soft_ack
);

    localparam int                   c_idx_w     = (NDOM > 1) ? $clog2(NDOM) : 1;
    localparam logic [c_idx_w-1:0]   c_idx_last  = c_idx_w'(NDOM - 1);
    localparam logic [c_idx_w-1:0]   c_idx_one   = c_idx_w'(1);
    localparam logic [CNT_W-1:0]     c_hold_term = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]     c_rel_term  = CNT_W'(REL_DLY - 1);
    // The acceptance cycle already counts as the first hold cycle
    localparam logic [CNT_W-1:0]     c_soft_ld   = CNT_W'(1);

    state_t               r_state,    w_state_nxt;
    logic [NDOM-1:0]      r_sel,      w_sel_nxt;
    logic [NDOM-1:0]      r_dom_rst,  w_dom_rst_nxt;
    logic [c_idx_w-1:0]   r_idx,      w_idx_nxt;
    logic                 r_armed,    w_armed_nxt;
    logic                 r_soft,     w_soft_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_seq_done, w_seq_done_nxt;
    logic                 r_soft_ack, w_soft_ack_nxt;

    logic                 w_cnt_clr;
    logic                 w_cnt_ld;
    logic                 w_cnt_en;
    logic [CNT_W-1:0]     w_cnt_term;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_cnt_tc;

    ctrl_rst_dly #(
        .CNT_W (CNT_W)
    ) u_dly (
        .clk      (clk),
        .i_clr    (~rst_n | w_cnt_clr),
        .i_ld     (w_cnt_ld),
        .i_ld_val (c_soft_ld),
        .i_en     (w_cnt_en),
        .i_term   (w_cnt_term),
        .o_cnt    (w_cnt),
        .o_tc     (w_cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_ASSERT;
            r_sel      <= '1;
            r_dom_rst  <= '1;
            r_idx      <= '0;
            r_armed    <= 1'b0;
            r_soft     <= 1'b0;
            r_busy     <= 1'b1;
            r_seq_done <= 1'b0;
            r_soft_ack <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_dom_rst  <= w_dom_rst_nxt;
            r_idx      <= w_idx_nxt;
            r_armed    <= w_armed_nxt;
            r_soft     <= w_soft_nxt;
            r_busy     <= w_busy_nxt;
            r_seq_done <= w_seq_done_nxt;
            r_soft_ack <= w_soft_ack_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_dom_rst_nxt  = r_dom_rst;
        w_idx_nxt      = r_idx;
        w_armed_nxt    = r_armed | ~soft_req;
        w_soft_nxt     = r_soft;
        w_busy_nxt     = r_busy;
        w_seq_done_nxt = r_seq_done;
        w_soft_ack_nxt = 1'b0;
        w_cnt_clr      = 1'b0;
        w_cnt_ld       = 1'b0;
        w_cnt_en       = 1'b0;
        w_cnt_term     = c_rel_term;

        case (r_state)
            ST_ASSERT: begin
                w_cnt_term = c_hold_term;
                if (w_cnt_tc) begin
                    w_state_nxt = ST_RELEASE;
                    w_idx_nxt   = '0;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            ST_RELEASE: begin
                // Each index releases on its first step cycle, then burns the gap
                if ((w_cnt == '0) && r_sel[r_idx]) begin
                    w_dom_rst_nxt[r_idx] = 1'b0;
                end
                if (r_idx == c_idx_last) begin
                    w_cnt_clr  = 1'b1;
                    w_busy_nxt = 1'b0;
                    if (r_soft) begin
                        w_soft_ack_nxt = 1'b1;
                        w_state_nxt    = ST_ACK;
                    end else begin
                        w_seq_done_nxt = 1'b1;
                        w_state_nxt    = ST_RUN;
                    end
                end else if (w_cnt_tc) begin
                    w_idx_nxt = r_idx + c_idx_one;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end

            ST_RUN: begin
                if (soft_req && r_armed) begin
                    w_armed_nxt = 1'b0;
                    w_sel_nxt   = soft_mask;
                    w_soft_nxt  = 1'b1;
                    if (soft_mask == '0) begin
                        w_soft_ack_nxt = 1'b1;
                        w_state_nxt    = ST_ACK;
                    end else begin
                        w_dom_rst_nxt = r_dom_rst | soft_mask;
                        w_busy_nxt    = 1'b1;
                        if (HOLD_CYC == 1) begin
                            w_state_nxt = ST_RELEASE;
                            w_idx_nxt   = '0;
                            w_cnt_clr   = 1'b1;
                        end else begin
                            w_state_nxt = ST_ASSERT;
                            w_cnt_ld    = 1'b1;
                        end
                    end
                end
            end

            ST_ACK: begin
                w_soft_nxt  = 1'b0;
                w_state_nxt = ST_RUN;
            end

            default: begin
                w_state_nxt = ST_ASSERT;
            end
        endcase
    end

    assign dom_rst  = r_dom_rst;
    assign busy     = r_busy;
    assign seq_done = r_seq_done;
    assign soft_ack = r_soft_ack;

endmodule : ctrl_rst_seq
`default_nettype wire
